nios_ocimem_debug_access: RTL and testbench



---
 rtl/nios_ocimem_pkg.sv | 22 ++
 rtl/nios_ocimem_ram.sv | 35 +++
 rtl/nios_ocimem_debug_access.sv | 228 ++++++++++++++++++++++
 tb/tb_nios_ocimem_debug_access.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/nios_ocimem_pkg.sv
// Shared types and jdo field positions for the debug-memory access block.
package nios_ocimem_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DBG_RD = 2'd1,
    CPU_RD = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    CMD_ADDR = 2'd0,  // take_action_ocimem_a: address load / read arm
    CMD_RD   = 2'd1,  // take_no_action_ocimem_a: streamed read
    CMD_WR   = 2'd2   // take_action_ocimem_b: streamed write
  } cmd_t;

  localparam int JDO_W         = 38;
  localparam int JDO_LOAD_ADDR = 35;
  localparam int JDO_RD_GO     = 34;
  localparam int JDO_WDATA_LSB = 3;
  localparam int JDO_ADDR_LSB  = 17;

endpackage

// File: rtl/nios_ocimem_ram.sv
// Single-port 32-bit RAM with byte enables and one cycle of read latency.
// A write returns the previous word on q (read-before-write); q holds when en is low.
module nios_ocimem_ram #(
  parameter int    ADDR_W    = 8,
  parameter string INIT_FILE = ""
) (
  input  logic              clk,
  input  logic              en,
  input  logic              we,
  input  logic [3:0]        be,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       q
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [31:0] mem [DEPTH];
  logic [31:0] q_reg;

  // Byte-lane writes and registered read of the addressed word.
  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        for (int b = 0; b < 4; b++) begin
          if (be[b]) mem[addr][b*8 +: 8] <= wdata[b*8 +: 8];
        end
      end
      q_reg <= mem[addr];
    end
  end

  assign q = q_reg;

endmodule

// File: rtl/nios_ocimem_debug_access.sv
// On-chip debug memory: arbitrates JTAG debug commands (address load, streamed
// read/write) against CPU Avalon-MM accesses, and reports MonDReg/ready/error.
module nios_ocimem_debug_access
  import nios_ocimem_pkg::*;
#(
  parameter int    ADDR_W    = 8,
  parameter string INIT_FILE = ""
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [JDO_W-1:0]  jdo,
  input  logic              take_action_ocimem_a,
  input  logic              take_action_ocimem_b,
  input  logic              take_no_action_ocimem_a,
  input  logic              debugack,
  input  logic [ADDR_W-1:0] avs_address,
  input  logic              avs_read,
  input  logic              avs_write,
  input  logic [31:0]       avs_writedata,
  input  logic [3:0]        avs_byteenable,
  output logic [31:0]       avs_readdata,
  output logic              avs_waitrequest,
  output logic [31:0]       MonDReg,
  output logic              monitor_ready,
  output logic              monitor_error,
  output logic [ADDR_W-1:0] dbg_addr
);

  state_t            state_reg, state_next;
  logic [ADDR_W-1:0] dbg_addr_reg, dbg_addr_next;
  logic [31:0]       mon_dreg_reg, mon_dreg_next;
  logic              ready_reg, ready_next;
  logic              error_reg, error_next;
  logic [31:0]       readdata_reg, readdata_next;
  logic              stream_reg, stream_next;     // current debug read advances dbg_addr
  logic              pend_valid_reg, pend_valid_next;
  cmd_t              pend_type_reg, pend_type_next;
  logic [JDO_W-1:0]  pend_jdo_reg, pend_jdo_next;

  logic              new_valid;
  cmd_t              new_type;
  logic              exec_valid;
  cmd_t              exec_type;
  logic [JDO_W-1:0]  exec_jdo;
  logic [ADDR_W-1:0] load_addr;
  logic              grant;

  logic              ram_en, ram_we;
  logic [3:0]        ram_be;
  logic [ADDR_W-1:0] ram_addr;
  logic [31:0]       ram_wdata, ram_q;

  logic              unused_jdo_bits;

  assign new_valid = take_action_ocimem_a | take_action_ocimem_b | take_no_action_ocimem_a;

  // Classify the incoming debug pulse (one pulse per cycle is expected).
  always_comb begin
    new_type = CMD_RD;
    if (take_action_ocimem_a)      new_type = CMD_ADDR;
    else if (take_action_ocimem_b) new_type = CMD_WR;
  end

  // Arbitration, command execution and next-state logic.
  always_comb begin
    state_next      = state_reg;
    dbg_addr_next   = dbg_addr_reg;
    mon_dreg_next   = mon_dreg_reg;
    ready_next      = ready_reg;
    error_next      = error_reg;
    readdata_next   = readdata_reg;
    stream_next     = stream_reg;
    pend_valid_next = pend_valid_reg;
    pend_type_next  = pend_type_reg;
    pend_jdo_next   = pend_jdo_reg;
    exec_valid      = 1'b0;
    exec_type       = CMD_ADDR;
    exec_jdo        = '0;
    load_addr       = dbg_addr_reg;
    grant           = 1'b0;
    ram_en          = 1'b0;
    ram_we          = 1'b0;
    ram_be          = 4'h0;
    ram_addr        = dbg_addr_reg;
    ram_wdata       = avs_writedata;

    unique case (state_reg)
      IDLE: begin
        if (pend_valid_reg) begin
          // Pending command wins; a pulse arriving now takes over the freed slot.
          exec_valid      = 1'b1;
          exec_type       = pend_type_reg;
          exec_jdo        = pend_jdo_reg;
          pend_valid_next = new_valid;
          pend_type_next  = new_type;
          pend_jdo_next   = jdo;
        end else if (new_valid) begin
          exec_valid = 1'b1;
          exec_type  = new_type;
          exec_jdo   = jdo;
        end else if (avs_write) begin
          ram_en    = 1'b1;
          ram_we    = 1'b1;
          ram_be    = avs_byteenable;
          ram_addr  = avs_address;
          ram_wdata = avs_writedata;
          grant     = 1'b1;
        end else if (avs_read) begin
          ram_en     = 1'b1;
          ram_addr   = avs_address;
          state_next = CPU_RD;
        end
      end
      DBG_RD: begin
        mon_dreg_next = ram_q;
        ready_next    = 1'b1;
        if (stream_reg) dbg_addr_next = dbg_addr_reg + ADDR_W'(1);
        state_next    = IDLE;
      end
      CPU_RD: begin
        readdata_next = ram_q;
        grant         = 1'b1;
        state_next    = IDLE;
      end
      default: state_next = IDLE;
    endcase

    // Debug pulses arriving while busy go to the one-deep slot, or are lost.
    if (state_reg != IDLE && new_valid) begin
      if (pend_valid_reg) begin
        error_next = 1'b1;
      end else begin
        pend_valid_next = 1'b1;
        pend_type_next  = new_type;
        pend_jdo_next   = jdo;
      end
    end

    if (exec_valid) begin
      unique case (exec_type)
        CMD_ADDR: begin
          error_next = 1'b0;
          ready_next = 1'b0;
          if (exec_jdo[JDO_LOAD_ADDR]) load_addr = exec_jdo[JDO_ADDR_LSB +: ADDR_W];
          dbg_addr_next = load_addr;
          if (exec_jdo[JDO_RD_GO]) begin
            ram_en      = 1'b1;
            ram_addr    = load_addr;
            stream_next = 1'b0;
            state_next  = DBG_RD;
          end
        end
        CMD_RD: begin
          ram_en      = 1'b1;
          ram_addr    = dbg_addr_reg;
          ready_next  = 1'b0;
          stream_next = 1'b1;
          state_next  = DBG_RD;
        end
        CMD_WR: begin
          if (debugack) begin
            ram_en        = 1'b1;
            ram_we        = 1'b1;
            ram_be        = 4'hF;
            ram_addr      = dbg_addr_reg;
            ram_wdata     = exec_jdo[JDO_WDATA_LSB +: 32];
            dbg_addr_next = dbg_addr_reg + ADDR_W'(1);
          end else begin
            error_next = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // State and output registers; reset drops the pending slot and any CPU read.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg      <= IDLE;
      dbg_addr_reg   <= '0;
      mon_dreg_reg   <= '0;
      ready_reg      <= 1'b0;
      error_reg      <= 1'b0;
      readdata_reg   <= '0;
      stream_reg     <= 1'b0;
      pend_valid_reg <= 1'b0;
      pend_type_reg  <= CMD_ADDR;
      pend_jdo_reg   <= '0;
    end else begin
      state_reg      <= state_next;
      dbg_addr_reg   <= dbg_addr_next;
      mon_dreg_reg   <= mon_dreg_next;
      ready_reg      <= ready_next;
      error_reg      <= error_next;
      readdata_reg   <= readdata_next;
      stream_reg     <= stream_next;
      pend_valid_reg <= pend_valid_next;
      pend_type_reg  <= pend_type_next;
      pend_jdo_reg   <= pend_jdo_next;
    end
  end

  nios_ocimem_ram #(
    .ADDR_W    (ADDR_W),
    .INIT_FILE (INIT_FILE)
  ) u_ram (
    .clk   (clk),
    .en    (ram_en & ~reset),
    .we    (ram_we & ~reset),
    .be    (ram_be),
    .addr  (ram_addr),
    .wdata (ram_wdata),
    .q     (ram_q)
  );

  // Read data is forwarded straight from the RAM in the grant cycle so the
  // master sees it together with waitrequest low, then held in readdata_reg.
  assign avs_readdata    = (state_reg == CPU_RD) ? ram_q : readdata_reg;
  assign avs_waitrequest = reset | ((avs_read | avs_write) & ~grant);
  assign MonDReg         = mon_dreg_reg;
  assign monitor_ready   = ready_reg;
  assign monitor_error   = error_reg;
  assign dbg_addr        = dbg_addr_reg;

  assign unused_jdo_bits = ^{exec_jdo[JDO_W-1:JDO_LOAD_ADDR+1], exec_jdo[JDO_WDATA_LSB-1:0]};

endmodule

// File: tb/tb_nios_ocimem_debug_access.sv
// Directed bench for nios_ocimem_debug_access with expected-value queues.
module tb_nios_ocimem_debug_access;

  logic        clk = 1'b0;
  logic        reset;
  logic [37:0] jdo;
  logic        take_action_ocimem_a, take_action_ocimem_b, take_no_action_ocimem_a;
  logic        debugack;
  logic [7:0]  avs_address;
  logic        avs_read, avs_write;
  logic [31:0] avs_writedata;
  logic [3:0]  avs_byteenable;
  logic [31:0] avs_readdata;
  logic        avs_waitrequest;
  logic [31:0] MonDReg;
  logic        monitor_ready, monitor_error;
  logic [7:0]  dbg_addr;

  int          total = 0;
  int          bad   = 0;
  logic [31:0] model [256];
  logic [7:0]  dbg_addr_model;
  logic [31:0] dbg_q [$];
  logic [31:0] cpu_q [$];
  logic        ready_prev = 1'b0;
  logic [31:0] old_word;

  always #5 clk = ~clk;

  nios_ocimem_debug_access #(.ADDR_W(8), .INIT_FILE("")) dut (
    .clk                     (clk),
    .reset                   (reset),
    .jdo                     (jdo),
    .take_action_ocimem_a    (take_action_ocimem_a),
    .take_action_ocimem_b    (take_action_ocimem_b),
    .take_no_action_ocimem_a (take_no_action_ocimem_a),
    .debugack                (debugack),
    .avs_address             (avs_address),
    .avs_read                (avs_read),
    .avs_write               (avs_write),
    .avs_writedata           (avs_writedata),
    .avs_byteenable          (avs_byteenable),
    .avs_readdata            (avs_readdata),
    .avs_waitrequest         (avs_waitrequest),
    .MonDReg                 (MonDReg),
    .monitor_ready           (monitor_ready),
    .monitor_error           (monitor_error),
    .dbg_addr                (dbg_addr)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock; outputs sampled 1ns after the edge. A rising monitor_ready
  // pops the next expected MonDReg value.
  task automatic step();
    @(posedge clk);
    #1;
    if (monitor_ready === 1'b1 && ready_prev !== 1'b1) begin
      if (dbg_q.size() == 0) chk("dbg_ready_unexpected", {31'b0, monitor_ready}, 32'd0);
      else                   chk("dbg_mondreg", MonDReg, dbg_q.pop_front());
    end
    ready_prev = monitor_ready;
  endtask

  task automatic wait_dbg(input int budget);
    int n;
    n = 0;
    while (dbg_q.size() != 0 && n < budget) begin
      step();
      n++;
    end
    chk("dbg_drain", dbg_q.size(), 32'd0);
    dbg_q.delete();
  endtask

  task automatic cpu_write(input logic [7:0] a, input logic [31:0] d, input logic [3:0] be);
    int w;
    avs_address = a; avs_writedata = d; avs_byteenable = be; avs_write = 1'b1;
    for (int b = 0; b < 4; b++) if (be[b]) model[a][b*8 +: 8] = d[b*8 +: 8];
    w = 0;
    #1;
    while (avs_waitrequest && w < 20) begin step(); w++; #1; end
    chk("cpu_wr_wait", w, 32'd0);
    step();
    avs_write = 1'b0;
  endtask

  task automatic cpu_read(input logic [7:0] a, input int exp_wait, input bit with_dbg);
    int w;
    logic [31:0] exp_data;
    cpu_q.push_back(model[a]);
    avs_address = a; avs_read = 1'b1;
    if (with_dbg) begin
      dbg_q.push_back(model[dbg_addr_model]);
      dbg_addr_model++;
      take_no_action_ocimem_a = 1'b1;
    end
    w = 0;
    #1;
    while (avs_waitrequest && w < 20) begin
      step();
      take_no_action_ocimem_a = 1'b0;
      w++;
      #1;
    end
    take_no_action_ocimem_a = 1'b0;
    chk("cpu_rd_wait", w, exp_wait);
    exp_data = cpu_q.pop_front();
    chk("cpu_readdata", avs_readdata, exp_data);
    step();
    avs_read = 1'b0;
    chk("cpu_readdata_hold", avs_readdata, exp_data);
  endtask

  task automatic dbg_cmd_a(input logic load, input logic rd, input logic [7:0] a);
    jdo = '0;
    jdo[37:36] = 2'b11; jdo[2:0] = 3'b111;  // ignored bits set
    jdo[35] = load; jdo[34] = rd; jdo[24:17] = a;
    if (load) dbg_addr_model = a;
    if (rd) dbg_q.push_back(model[dbg_addr_model]);
    take_action_ocimem_a = 1'b1;
    step();
    take_action_ocimem_a = 1'b0;
  endtask

  task automatic dbg_cmd_b(input logic [31:0] d);
    jdo = '0;
    jdo[37:35] = 3'b111; jdo[2:0] = 3'b111;  // ignored bits set
    jdo[34:3] = d;
    if (debugack) begin
      model[dbg_addr_model] = d;
      dbg_addr_model++;
    end
    take_action_ocimem_b = 1'b1;
    step();
    take_action_ocimem_b = 1'b0;
  endtask

  task automatic dbg_cmd_na();
    dbg_q.push_back(model[dbg_addr_model]);
    dbg_addr_model++;
    take_no_action_ocimem_a = 1'b1;
    step();
    take_no_action_ocimem_a = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1; jdo = '0; debugack = 1'b0;
    take_action_ocimem_a = 1'b0; take_action_ocimem_b = 1'b0; take_no_action_ocimem_a = 1'b0;
    avs_address = '0; avs_read = 1'b0; avs_write = 1'b0; avs_writedata = '0; avs_byteenable = '0;
    dbg_addr_model = '0;
    step(); step();

    // Reset state.
    chk("rst_mondreg", MonDReg, 32'd0);
    chk("rst_ready", {31'b0, monitor_ready}, 32'd0);
    chk("rst_error", {31'b0, monitor_error}, 32'd0);
    chk("rst_dbg_addr", dbg_addr, 32'd0);
    chk("rst_readdata", avs_readdata, 32'd0);
    chk("rst_wait", {31'b0, avs_waitrequest}, 32'd1);
    reset = 1'b0;
    #1;
    chk("idle_wait", {31'b0, avs_waitrequest}, 32'd0);
    step();

    // Preload through the CPU port, including a partial byte-enable write.
    cpu_write(8'h10, 32'hDEADBEEF, 4'hF);
    cpu_write(8'h05, 32'h0505A5A5, 4'hF);
    cpu_write(8'h11, 32'h11110011, 4'hF);
    cpu_write(8'h12, 32'h12120012, 4'hF);
    cpu_write(8'h13, 32'h13130013, 4'hF);
    cpu_write(8'h20, 32'hAAAA0000, 4'hF);
    cpu_write(8'h06, 32'hFFFFFFFF, 4'hF);
    cpu_write(8'h06, 32'h12345678, 4'b0101);
    cpu_read(8'h06, 1, 1'b0);
    chk("byteenable_merge", avs_readdata, 32'hFF34FF78);

    // Address load plus read: ready two cycles after the pulse.
    dbg_cmd_a(1'b1, 1'b1, 8'h10);
    chk("ld_rd_ready_early", {31'b0, monitor_ready}, 32'd0);
    step();
    chk("ld_rd_ready", {31'b0, monitor_ready}, 32'd1);
    chk("ld_rd_dbg_addr", dbg_addr, 32'h10);
    wait_dbg(2);

    // Streamed writes wrapping the address, then streamed read-back.
    debugack = 1'b1;
    dbg_cmd_a(1'b1, 1'b0, 8'hFE);
    chk("wr_load_addr", dbg_addr, 32'hFE);
    dbg_cmd_b(32'h11111111);
    chk("wr1_dbg_addr", dbg_addr, 32'hFF);
    dbg_cmd_b(32'h22222222);
    chk("wr2_dbg_addr_wrap", dbg_addr, 32'h00);
    dbg_cmd_a(1'b1, 1'b0, 8'hFE);
    dbg_cmd_na();
    wait_dbg(4);
    dbg_cmd_na();
    wait_dbg(4);
    chk("rd_stream_wrap", dbg_addr, {24'b0, dbg_addr_model});

    // Debug write without debugack is rejected.
    dbg_cmd_a(1'b1, 1'b0, 8'h10);
    debugack = 1'b0;
    dbg_cmd_b(32'hCAFEF00D);
    chk("nack_error", {31'b0, monitor_error}, 32'd1);
    chk("nack_dbg_addr", dbg_addr, 32'h10);
    cpu_read(8'h10, 1, 1'b0);
    dbg_cmd_a(1'b0, 1'b0, 8'h00);
    chk("nack_error_clear", {31'b0, monitor_error}, 32'd0);
    chk("noload_dbg_addr", dbg_addr, 32'h10);
    debugack = 1'b1;

    // CPU read and debug read in the same cycle: debug first, 3 wait cycles.
    cpu_read(8'h05, 3, 1'b1);
    wait_dbg(2);
    chk("contend_dbg_addr", dbg_addr, 32'h11);

    // Four back-to-back streamed-read pulses: three served, the last dropped.
    dbg_q.push_back(model[8'h11]);
    dbg_q.push_back(model[8'h12]);
    dbg_q.push_back(model[8'h13]);
    dbg_addr_model = 8'h14;
    take_no_action_ocimem_a = 1'b1;
    step(); step(); step(); step();
    take_no_action_ocimem_a = 1'b0;
    wait_dbg(8);
    chk("overrun_error", {31'b0, monitor_error}, 32'd1);
    chk("overrun_dbg_addr", dbg_addr, 32'h14);

    // Debug write landing during CPU_RD does not disturb that read.
    dbg_cmd_a(1'b1, 1'b0, 8'h20);
    old_word = model[8'h20];
    avs_address = 8'h20; avs_read = 1'b1;
    #1;
    chk("rbw_wait_issue", {31'b0, avs_waitrequest}, 32'd1);
    step();
    jdo = '0; jdo[34:3] = 32'hBBBB1111; take_action_ocimem_b = 1'b1;
    #1;
    chk("rbw_wait_grant", {31'b0, avs_waitrequest}, 32'd0);
    chk("rbw_old_data", avs_readdata, old_word);
    step();
    take_action_ocimem_b = 1'b0; avs_read = 1'b0;
    model[8'h20] = 32'hBBBB1111;
    dbg_addr_model = 8'h21;
    step();
    chk("rbw_dbg_addr", dbg_addr, 32'h21);
    cpu_read(8'h20, 1, 1'b0);

    // Reset in the middle of a CPU read.
    debugack = 1'b0;
    dbg_cmd_b(32'h0);
    chk("pre_rst_error", {31'b0, monitor_error}, 32'd1);
    debugack = 1'b1;
    avs_address = 8'h05; avs_read = 1'b1;
    step();
    reset = 1'b1;
    #1;
    chk("rst_mid_wait", {31'b0, avs_waitrequest}, 32'd1);
    step();
    chk("rst_mid_mondreg", MonDReg, 32'd0);
    chk("rst_mid_ready", {31'b0, monitor_ready}, 32'd0);
    chk("rst_mid_error", {31'b0, monitor_error}, 32'd0);
    chk("rst_mid_dbg_addr", dbg_addr, 32'd0);
    chk("rst_mid_readdata", avs_readdata, 32'd0);
    chk("rst_mid_wait_held", {31'b0, avs_waitrequest}, 32'd1);
    avs_read = 1'b0; reset = 1'b0;
    dbg_addr_model = 8'h00;
    #1;
    chk("post_rst_wait", {31'b0, avs_waitrequest}, 32'd0);
    step();
    dbg_cmd_a(1'b1, 1'b1, 8'h10);
    wait_dbg(4);
    chk("post_rst_dbg_addr", dbg_addr, 32'h10);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
